// File: rtl/sync_dd_c_pkg.sv
// Shared constants for the sync_dd_c synchronizer slice.
// Holds the legal bounds on the number of flops per synchronizer chain so
// the range check in the top level and any future user agree on them.
package sync_dd_c_pkg;

  // A chain shorter than 2 gives no metastability settling time; longer
  // than 4 only adds latency without a practical MTBF benefit here.
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

endpackage

// File: rtl/sync_dd_bit.sv
// Single-bit multi-flop synchronizer with registered edge history.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset_   - synchronous, active-high reset; loads RESET_VAL everywhere
//   sync_in  - asynchronous input bit
//   sync_out - last stage of the chain
//   rise     - sync_out went 0->1 on the last edge (one cycle)
//   fall     - sync_out went 1->0 on the last edge (one cycle)
module sync_dd_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_,
  input  logic sync_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  // Stage flops must stay discrete and adjacent: no merging, retiming or
  // mapping into shift-register primitives, or the settling time is lost.
  (* ASYNC_REG = "TRUE", keep = "true", shreg_extract = "no" *)
  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;
  logic              prev_q;

  // stage_q[0] is the capture flop; data moves toward the MSB.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], sync_in};
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      stage_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      stage_q <= stage_d;
      prev_q  <= stage_q[STAGES-1];
    end
  end

  assign sync_out = stage_q[STAGES-1];

  // Flags depend only on registers, so nothing combinational reaches the
  // outputs from sync_in.
  assign rise = stage_q[STAGES-1] & ~prev_q;
  assign fall = ~stage_q[STAGES-1] & prev_q;

endmodule

// File: rtl/sync_dd_c.sv
// Multi-bit, multi-flop synchronizer bringing asynchronous pins (e.g. UART
// RX) into the clk domain, with per-bit registered rise/fall flags.
// Each bit has its own chain; bits of a word may arrive on different cycles.
//
// Parameters:
//   WIDTH     - number of independently synchronized bits
//   STAGES    - flops per chain, 2..4
//   RESET_VAL - value loaded into every stage and the edge history on reset
//
// Ports:
//   clk      - sole clock, rising edge
//   reset_   - synchronous, active-high reset
//   sync_in  - asynchronous input word
//   sync_out - synchronized word (last stage of each chain)
//   rise     - per-bit one-cycle 0->1 flag
//   fall     - per-bit one-cycle 1->0 flag
module sync_dd_c
  import sync_dd_c_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_dd_c: STAGES must be within 2..4");
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sync_dd_bit #(
      .STAGES    (STAGES),
      .RESET_VAL (RESET_VAL[g])
    ) u_bit (
      .clk      (clk),
      .reset_   (reset_),
      .sync_in  (sync_in[g]),
      .sync_out (sync_out[g]),
      .rise     (rise[g]),
      .fall     (fall[g])
    );
  end

`ifndef SYNTHESIS
  // Counts edges since reset release, saturating once the chains have had
  // time to flush; after that a known input must give a known output.
  localparam logic [2:0] SETTLE = 3'(STAGES);
  logic [2:0] settle_q;

  always_ff @(posedge clk) begin
    if (reset_) begin
      settle_q <= 3'd0;
    end else if (settle_q <= SETTLE) begin
      settle_q <= settle_q + 3'd1;
    end
  end

  a_out_known : assert property (@(posedge clk) disable iff (reset_)
    ((settle_q > SETTLE) && !$isunknown(sync_in)) |-> !$isunknown(sync_out));
`endif

endmodule

// File: tb/tb_sync_dd_c.sv
// Directed bench for sync_dd_c: three instances (1x2 stages reset 0,
// 4x3 stages reset 0, 2x4 stages reset 2'b10) on one clock and reset.
module tb_sync_dd_c;

  logic       clk;
  logic       reset_;
  logic       in_a;
  logic       out_a, rise_a, fall_a;
  logic [3:0] in_b, out_b, rise_b, fall_b;
  logic [1:0] in_c, out_c, rise_c, fall_c;

  int n_total = 0;
  int n_pass  = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_dd_c #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0)) u_a (
    .clk(clk), .reset_(reset_), .sync_in(in_a),
    .sync_out(out_a), .rise(rise_a), .fall(fall_a)
  );

  sync_dd_c #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'b0000)) u_b (
    .clk(clk), .reset_(reset_), .sync_in(in_b),
    .sync_out(out_b), .rise(rise_b), .fall(fall_b)
  );

  sync_dd_c #(.WIDTH(2), .STAGES(4), .RESET_VAL(2'b10)) u_c (
    .clk(clk), .reset_(reset_), .sync_in(in_c),
    .sync_out(out_c), .rise(rise_c), .fall(fall_c)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_a(input string tag, input logic o, input logic r, input logic f);
    chk({tag, ".out_a"},  8'(out_a),  8'(o));
    chk({tag, ".rise_a"}, 8'(rise_a), 8'(r));
    chk({tag, ".fall_a"}, 8'(fall_a), 8'(f));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    chk({tag, ".out_b"},  8'(out_b),  8'(o));
    chk({tag, ".rise_b"}, 8'(rise_b), 8'(r));
    chk({tag, ".fall_b"}, 8'(fall_b), 8'(f));
  endtask

  task automatic chk_c(input string tag, input logic [1:0] o, input logic [1:0] r, input logic [1:0] f);
    chk({tag, ".out_c"},  8'(out_c),  8'(o));
    chk({tag, ".rise_c"}, 8'(rise_c), 8'(r));
    chk({tag, ".fall_c"}, 8'(fall_c), 8'(f));
  endtask

  initial begin
    reset_ = 1'b1;
    in_a   = 1'b1;
    in_b   = 4'b0000;
    in_c   = 2'b01;

    // Reset held 3 edges with inputs differing from RESET_VAL.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("rst", 1'b0, 1'b0, 1'b0);
      chk_b("rst", 4'b0000, 4'b0000, 4'b0000);
      chk_c("rst", 2'b10, 2'b00, 2'b00);
    end

    // Release: A (2 stages) changes on the 2nd edge, C (4 stages) on the 4th.
    reset_ = 1'b0;
    tick(); chk_a("rel1", 1'b0, 1'b0, 1'b0); chk_c("rel1", 2'b10, 2'b00, 2'b00);
    tick(); chk_a("rel2", 1'b1, 1'b1, 1'b0); chk_c("rel2", 2'b10, 2'b00, 2'b00);
    tick(); chk_a("rel3", 1'b1, 1'b0, 1'b0); chk_c("rel3", 2'b10, 2'b00, 2'b00);
    tick(); chk_c("rel4", 2'b01, 2'b01, 2'b10);
    tick(); chk_c("rel5", 2'b01, 2'b00, 2'b00); chk_b("rel5", 4'b0000, 4'b0000, 4'b0000);

    // Falling edge (start bit), driven just after an edge.
    in_a = 1'b0;
    tick(); chk_a("fall1", 1'b1, 1'b0, 1'b0);
    tick(); chk_a("fall2", 1'b0, 1'b0, 1'b1);
    tick(); chk_a("fall3", 1'b0, 1'b0, 1'b0);

    // Rising edge latency.
    in_a = 1'b1;
    tick(); chk_a("lat1", 1'b0, 1'b0, 1'b0);
    tick(); chk_a("lat2", 1'b1, 1'b1, 1'b0);
    tick(); chk_a("lat3", 1'b1, 1'b0, 1'b0);

    // Return A to 0 before the mid-operation reset.
    in_a = 1'b0;
    tick(); tick(); tick();
    chk_a("idle", 1'b0, 1'b0, 1'b0);

    // Mid-operation reset: stage[0]=1 while sync_out is still 0.
    in_a = 1'b1;
    tick(); chk_a("mid0", 1'b0, 1'b0, 1'b0);
    reset_ = 1'b1;
    tick(); chk_a("midrst", 1'b0, 1'b0, 1'b0); chk_c("midrst", 2'b10, 2'b00, 2'b00);
    reset_ = 1'b0;
    tick(); chk_a("midr1", 1'b0, 1'b0, 1'b0);
    tick(); chk_a("midr2", 1'b1, 1'b1, 1'b0);
    tick(); chk_a("midr3", 1'b1, 1'b0, 1'b0); chk_c("midr3", 2'b10, 2'b00, 2'b00);
    tick(); chk_c("midr4", 2'b01, 2'b01, 2'b10);

    // Multi-bit word on the 3-stage instance.
    in_b = 4'b1010;
    tick(); chk_b("mb1", 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("mb2", 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("mb3", 4'b1010, 4'b1010, 4'b0000);
    tick(); chk_b("mb4", 4'b1010, 4'b0000, 4'b0000);
    in_b = 4'b0110;
    tick(); chk_b("mb5", 4'b1010, 4'b0000, 4'b0000);
    tick(); chk_b("mb6", 4'b1010, 4'b0000, 4'b0000);
    tick(); chk_b("mb7", 4'b0110, 4'b0100, 4'b1000);
    tick(); chk_b("mb8", 4'b0110, 4'b0000, 4'b0000);

    // Narrow glitch between two edges is never sampled.
    in_a = 1'b0;
    tick(); tick(); tick();
    chk_a("preg", 1'b0, 1'b0, 1'b0);
    in_a = 1'b1;
    #3;
    in_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("glitch", 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
